axil_reg_slave: RTL
===================

# axil_reg_slave

AXI4-Lite responder that terminates the bus driven by the UART-side native-to-AXI bridge. It owns a small bank of W-bit control registers for the HDMI driver (timing and pattern configuration). Registers are exposed as flat outputs with a per-register write strobe. The write path accepts AW and W independently and in either order; the read path is a single-beat registered return. Out-of-range accesses return SLVERR.

## Interface
- W, 32, data width; must be 32 (4 byte lanes)
- A, 4, byte-address width; register index = addr[A-1:2]
- NREG, 3, number of implemented registers; must be 1..2^(A-2)
- clk_i  in  1  clock; all logic on rising edge
- rst_n_i  in  1  reset; synchronous, active-low
- s_axi_awaddr  in  A  write address
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  W  write data
- s_axi_wstrb  in  W/8  byte-lane enables
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_araddr  in  A  read address
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  W  read data
- s_axi_rresp  out  2  read response, same encoding as bresp
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- reg_o  out  NREG*W  register contents; register i at reg_o[i*W +: W]
- wr_stb_o  out  NREG  one-cycle pulse, bit i set in the cycle after register i is written

## Operation
- Write channel state: aw_held flag + latched awaddr, w_held flag + latched wdata/wstrb.
- awready = !aw_held && !bvalid; wready = !w_held && !bvalid (combinational from registered state).
- AW handshake = awvalid && awready; W handshake likewise.
- Commit condition at an edge: (aw_held || AW handshake) && (w_held || W handshake). Address/data taken from the handshake if present, else from the held copy.
- On commit: idx = addr[A-1:2]; if idx < NREG, each byte lane b with wstrb[b]=1 updates reg[idx][8b+7:8b], bresp <= 2'b00, wr_stb_o[idx] <= 1; else no register change, bresp <= 2'b10, wr_stb_o stays 0. bvalid <= 1, both held flags cleared.
- Handshake without commit sets the corresponding held flag and latches its payload.
- bvalid cleared on bvalid && bready; new AW/W are blocked while bvalid is high.
- wstrb = 0 with valid idx: OKAY, no byte changes, wr_stb_o[idx] still pulses.
- Read: arready = !rvalid. On AR handshake: idx = araddr[A-1:2]; rdata <= reg[idx], rresp <= 2'b00 if idx < NREG, else rdata <= 0, rresp <= 2'b10; rvalid <= 1. rvalid cleared on rvalid && rready; rdata/rresp hold while rvalid && !rready.
- Read and write paths are independent; AR and a commit to the same register on the same edge: read returns the pre-write value.
- addr[1:0] ignored on both paths.
- wr_stb_o is a pulse: every bit returns to 0 one cycle after assertion.

## Timing
- Reset (rst_n_i=0 at an edge): reg_o=0, wr_stb_o=0, bvalid=0, bresp=0, rvalid=0, rdata=0, rresp=0, held flags cleared; therefore awready=wready=arready=1 in the first cycle after reset. Reset mid-transaction drops any held AW/W and any pending B/R response without side effects.
- AW and W handshake on the same edge t: reg_o updated, bvalid=1 after edge t; wr_stb_o high for the cycle following edge t.
- AW at edge t, W at edge t+k: commit at t+k; same one-edge latency from the second handshake. W-before-AW symmetric.
- Max write throughput: one write per 2 cycles with bready tied high. Read throughput: one per 2 cycles with rready tied high.
- Read latency: rvalid=1 immediately after the AR handshake edge.

## Test plan
- Reset then AW=0x4 and W=0xDEADBEEF with wstrb=0xF in the same cycle, bready=1 -> bvalid 1 cycle later with bresp=00, reg_o[63:32]=0xDEADBEEF, wr_stb_o=3'b010 for one cycle; read 0x4 -> rdata=0xDEADBEEF, rresp=00.
- W (0x11223344, wstrb=0x5) 3 cycles before AW=0x0 on a register holding 0xAABBCCDD -> wready drops after W, bvalid one cycle after AW, reg0=0xAA22CC44.
- Write and read to 0xC (idx 3 >= NREG) -> bresp=10, reg_o unchanged, wr_stb_o=0; rresp=10, rdata=0.
- bready held low 5 cycles after bvalid -> bvalid, bresp stable, awready=wready=0 throughout; second queued write commits only after B handshake.
- AR to 0x8 on the same edge as a commit of 0x55 to 0x8 (old 0x0) -> rdata=0x0; subsequent read -> 0x55. rready low 4 cycles -> rdata/rvalid held, arready=0.
- AW accepted, rst_n_i low for 1 cycle before W arrives -> all outputs at reset values, W alone afterwards does not commit (wready drops, bvalid stays 0 until a new AW).

Source files
------------

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite register bank for HDMI timing/pattern control.
// AW and W are accepted independently and committed once both are present.
module axil_reg_slave #(
    parameter int W    = 32,
    parameter int A    = 4,
    parameter int NREG = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [A-1:0]      s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [W-1:0]      s_axi_wdata,
    input  logic [W/8-1:0]    s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [A-1:0]      s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [W-1:0]      s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [NREG*W-1:0] reg_o,
    output logic [NREG-1:0]   wr_stb_o
);
    localparam int NB = W / 8;
    logic            aw_held, w_held;
    logic [A-1:0]    aw_addr;
    logic [W-1:0]    w_data;
    logic [NB-1:0]   w_strb;
    logic [W-1:0]    regs [NREG];
    logic            aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [A-1:0]    c_addr;
    logic [W-1:0]    c_data, rd_val;
    logic [NB-1:0]   c_strb;
    logic [A-3:0]    c_idx, r_idx;
    assign s_axi_awready = !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = !w_held && !s_axi_bvalid;
    assign s_axi_arready = !s_axi_rvalid;
    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);
    // a fresh handshake takes priority over a held copy; only one side can be held at a time
    assign c_addr = aw_hs ? s_axi_awaddr : aw_addr;
    assign c_data = w_hs ? s_axi_wdata : w_data;
    assign c_strb = w_hs ? s_axi_wstrb : w_strb;
    assign c_idx  = c_addr[A-1:2];
    assign r_idx  = s_axi_araddr[A-1:2];
    assign wr_ok  = int'(c_idx) < NREG;
    assign rd_ok  = int'(r_idx) < NREG;
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREG; i++)
            if (int'(r_idx) == i) rd_val = regs[i];
    end
    for (genvar i = 0; i < NREG; i++) begin : g_out
        assign reg_o[i*W +: W] = regs[i];
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            wr_stb_o     <= '0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr      <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
        end else begin
            wr_stb_o <= '0;
            if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? 2'b00 : 2'b10;
                for (int i = 0; i < NREG; i++) begin
                    if (wr_ok && int'(c_idx) == i) begin
                        wr_stb_o[i] <= 1'b1;
                        for (int b = 0; b < NB; b++)
                            if (c_strb[b]) regs[i][8*b +: 8] <= c_data[8*b +: 8];
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_addr <= s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_data <= s_axi_wdata;
                    w_strb <= s_axi_wstrb;
                end
            end
            if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_ok ? rd_val : '0;
                s_axi_rresp  <= rd_ok ? 2'b00 : 2'b10;
            end
        end
    end
endmodule
